// File: rtl/fifo_wr_ptr_full.sv
// -----------------------------------------------------------------------------
// fifo_wr_ptr_full
//
// Write-side pointer and full-flag generator for an asynchronous FIFO. The
// whole block runs in the write clock domain. It keeps a binary write pointer
// that advances on accepted writes, drives the memory write address from the
// low bits of that pointer, and publishes a registered Gray-coded pointer for
// the read-domain synchronizer. Full is registered and is raised by comparing
// the next Gray write pointer against the read-domain Gray pointer.
//
// Parameters:
//   Addr_width    pointer width including the wrap bit (>= 3). The FIFO
//                 depth is 2**(Addr_width-1).
//
// Ports:
//   CLK           write-domain clock, rising edge
//   RST           asynchronous active-high reset
//   W_INC         write request
//   Rd_gray_ptr   read-domain Gray pointer (already synchronized, or raw
//                 when RD_PTR_SYNC_EN is defined)
//   W_addr        memory write address, low bits of the binary pointer
//   Wr_gray_ptr   registered Gray write pointer, to the read domain
//   Full          registered full flag
//
// Build option:
//   RD_PTR_SYNC_EN  when defined, Rd_gray_ptr passes through an internal
//                   two-flop synchronizer clocked by CLK. When undefined,
//                   Rd_gray_ptr is used directly and the synchronizer lives
//                   outside this block.
//
// Handshake: W_INC acts as valid and !Full as ready; a write is accepted on a
// rising CLK edge exactly when W_INC && !Full. A write presented while Full
// is dropped silently and the pointers hold.
// -----------------------------------------------------------------------------
module fifo_wr_ptr_full #(
    parameter int Addr_width = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  W_INC,
    input  logic [Addr_width-1:0] Rd_gray_ptr,
    output logic [Addr_width-2:0] W_addr,
    output logic [Addr_width-1:0] Wr_gray_ptr,
    output logic                  Full
);

    logic [Addr_width-1:0] wbin;
    logic [Addr_width-1:0] wbin_next;
    logic [Addr_width-1:0] wgray_next;
    logic [Addr_width-1:0] rq;
    logic [Addr_width-1:0] rq_full;
    logic                  accept;

`ifdef RD_PTR_SYNC_EN
    // Two-flop synchronizer for the raw cross-domain read pointer. Only one
    // bit of a Gray pointer changes per read step, so a late-captured bit
    // resolves to either the old or the new pointer value.
    logic [Addr_width-1:0] rq1;
    logic [Addr_width-1:0] rq2;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rq1 <= '0;
            rq2 <= '0;
        end else begin
            rq1 <= Rd_gray_ptr;
            rq2 <= rq1;
        end
    end

    assign rq = rq2;
`else
    assign rq = Rd_gray_ptr;
`endif

    always_comb begin
        accept     = W_INC & ~Full;
        wbin_next  = wbin + {{(Addr_width-1){1'b0}}, accept};
        wgray_next = wbin_next ^ (wbin_next >> 1);
        // In Gray code, "one full lap ahead" means the two MSBs differ and
        // every lower bit matches.
        rq_full    = {~rq[Addr_width-1], ~rq[Addr_width-2], rq[Addr_width-3:0]};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wbin        <= '0;
            Wr_gray_ptr <= '0;
            Full        <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            Wr_gray_ptr <= wgray_next;
            Full        <= (wgray_next == rq_full);
        end
    end

    assign W_addr = wbin[Addr_width-2:0];

endmodule

// File: tb/tb_fifo_wr_ptr_full.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_ptr_full
//
// Directed and randomized bench for fifo_wr_ptr_full (Addr_width = 5). The
// reference model tracks the write pointer as an integer count and the FIFO
// occupancy as (write count - read count) mod 32; Full is expected exactly
// when that occupancy equals the depth of 16. The read pointer the design
// sees is reconstructed from the Gray input, delayed by two edges when
// RD_PTR_SYNC_EN is defined.
// -----------------------------------------------------------------------------
module tb_fifo_wr_ptr_full;

    localparam int A     = 5;
    localparam int DEPTH = 16;
    localparam int MODV  = 32;
`ifdef RD_PTR_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif
    localparam int REL_LAT = SYNC ? 3 : 1;

    // clock / reset
    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         W_INC = 1'b0;
    logic [A-1:0] Rd_gray_ptr = '0;
    logic [A-2:0] W_addr;
    logic [A-1:0] Wr_gray_ptr;
    logic         Full;

    always #5 CLK = ~CLK;

    fifo_wr_ptr_full #(.Addr_width(A)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .W_INC       (W_INC),
        .Rd_gray_ptr (Rd_gray_ptr),
        .W_addr      (W_addr),
        .Wr_gray_ptr (Wr_gray_ptr),
        .Full        (Full)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int           m_wptr = 0;
    bit           m_full = 1'b0;
    logic [A-1:0] pipe0 = '0;
    logic [A-1:0] pipe1 = '0;

    function automatic logic [A-1:0] to_gray(input int v);
        logic [A-1:0] b;
        b = v[A-1:0];
        return b ^ (b >> 1);
    endfunction

    // Gray -> binary by search over all pointer values.
    function automatic int to_bin(input logic [A-1:0] g);
        for (int v = 0; v < MODV; v++)
            if (to_gray(v) == g) return v;
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_wptr = 0;
        m_full = 1'b0;
        pipe0  = '0;
        pipe1  = '0;
    endtask

    task automatic check_model();
        check("w_addr", {28'd0, W_addr}, m_wptr % DEPTH);
        check("wr_gray", {27'd0, Wr_gray_ptr}, {27'd0, to_gray(m_wptr)});
        check("full", {31'd0, Full}, {31'd0, m_full});
    endtask

    // driver: apply inputs, take one edge, advance model, check at negedge
    task automatic tick(input logic w, input logic [A-1:0] rd);
        logic [A-1:0] rq_eff;
        int           occ;
        W_INC       = w;
        Rd_gray_ptr = rd;
        @(posedge CLK);
        rq_eff = SYNC ? pipe1 : rd;
        if (w && !m_full) m_wptr = (m_wptr + 1) % MODV;
        occ    = (m_wptr - to_bin(rq_eff) + MODV) % MODV;
        m_full = (occ == DEPTH);
        pipe1  = pipe0;
        pipe0  = rd;
        @(negedge CLK);
        check_model();
    endtask

    // short asynchronous pulse between edges; called at a negedge
    task automatic pulse_reset(input string tag);
        W_INC       = $urandom_range(0, 1);
        Rd_gray_ptr = $urandom_range(0, MODV - 1);
        #2 RST = 1'b1;
        #1;
        check({tag, "_addr"}, {28'd0, W_addr}, 32'd0);
        check({tag, "_gray"}, {27'd0, Wr_gray_ptr}, 32'd0);
        check({tag, "_full"}, {31'd0, Full}, 32'd0);
        #1 RST = 1'b0;
        m_reset();
    endtask

    initial begin
        logic [A-1:0] prev_gray;
        int           prev_bin;
        int           wraps;
        int           rbin;
        int           occ;

        // reset with arbitrary inputs, checked before any clock edge
        W_INC       = $urandom_range(0, 1);
        Rd_gray_ptr = $urandom_range(0, MODV - 1);
        #2 RST = 1'b1;
        #1;
        check("rst0_addr", {28'd0, W_addr}, 32'd0);
        check("rst0_gray", {27'd0, Wr_gray_ptr}, 32'd0);
        check("rst0_full", {31'd0, Full}, 32'd0);
        repeat (2) @(negedge CLK);
        check("rst1_gray", {27'd0, Wr_gray_ptr}, 32'd0);
        RST = 1'b0;
        m_reset();

        // fill: 16 writes with the reader at 0
        for (int i = 0; i < DEPTH; i++) begin
            if (i < DEPTH - 1) check("fill_notfull", {31'd0, Full}, 32'd0);
            tick(1'b1, '0);
        end
        check("fill_gray", {27'd0, Wr_gray_ptr}, 32'b11000);
        check("fill_full", {31'd0, Full}, 32'd1);

        // write while full
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, '0);
            check("wfull_addr", {28'd0, W_addr}, 32'd0);
            check("wfull_gray", {27'd0, Wr_gray_ptr}, 32'b11000);
            check("wfull_full", {31'd0, Full}, 32'd1);
        end

        // read release: reader advances by one
        for (int k = 1; k <= REL_LAT; k++) begin
            tick(1'b0, 5'b00001);
            check("release_full", {31'd0, Full}, (k < REL_LAT) ? 32'd1 : 32'd0);
        end
        tick(1'b1, 5'b00001);
        check("release_gray", {27'd0, Wr_gray_ptr}, 32'b11001);

        // wrap / Gray property: reader trails the writer by 8
        repeat (3) tick(1'b0, to_gray(9));
        wraps = 0;
        for (int i = 0; i < 64; i++) begin
            prev_gray = Wr_gray_ptr;
            prev_bin  = m_wptr;
            tick(1'b1, to_gray((m_wptr + MODV - 8) % MODV));
            check("gray_hamming", $countones(prev_gray ^ Wr_gray_ptr), 32'd1);
            check("wrap_notfull", {31'd0, Full}, 32'd0);
            if (prev_bin == MODV - 1 && m_wptr == 0) wraps++;
        end
        check("wrap_count", wraps, 32'd2);

        // randomized traffic; reader never passes the writer
        rbin = (m_wptr + MODV - 8) % MODV;
        for (int i = 0; i < 400; i++) begin
            occ = (m_wptr - rbin + MODV) % MODV;
            if ($urandom_range(0, 2) == 0) rbin = (rbin + $urandom_range(0, occ)) % MODV;
            prev_gray = Wr_gray_ptr;
            tick(($urandom_range(0, 3) != 0), to_gray(rbin));
            check("rand_hamming_le1", ($countones(prev_gray ^ Wr_gray_ptr) <= 1), 32'd1);
        end

        // reset mid-fill
        @(negedge CLK);
        pulse_reset("rstA");
        for (int i = 0; i < 7; i++) tick(1'b1, '0);
        check("midfill_addr", {28'd0, W_addr}, 32'd7);
        pulse_reset("rstB");
        tick(1'b1, '0);
        check("after_rst_addr", {28'd0, W_addr}, 32'd1);
        check("after_rst_gray", {27'd0, Wr_gray_ptr}, 32'b00001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
